fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of the decoder. Holds the program counter, issues word requests to instruction memory over a req/ack handshake, and presents one 32-bit instruction per cycle with its address to decode. Applies taken-branch redirects (target and link address) fed back from decode/condition logic, squashing wrong-path fetches and inserting never-execute bubbles.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value fetched first after reset; must be word-aligned.
- `BUBBLE`, 32'hF000_0000: instruction emitted when no valid instruction is available. Condition field 4'b1111 never executes.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_req` out 1: fetch request; held with stable `imem_addr` until `imem_ack`.
- `imem_addr` out 32: word-aligned fetch address; bits [1:0] always 0.
- `imem_ack` in 1: completes the request; `imem_rdata` is valid in the same cycle. May be combinational from `imem_req`.
- `imem_rdata` in 32: fetched instruction word.
- `stall` in 1: decode cannot accept; hold `instruction`/`pc_out`.
- `branch_taken` in 1: instruction currently on `instruction` is a branch whose condition passed; sampled only when `inst_valid`=1.
- `branch_link` in 1: qualifies `branch_taken` as BL.
- `b_offset` in 32: sign-extended byte offset, already shifted left by 2.
- `instruction` out 32: instruction to decoder (`BUBBLE` when `inst_valid`=0).
- `inst_valid` out 1: `instruction`/`pc_out` hold a real fetched word.
- `pc_out` out 32: address of `instruction`.
- `link_addr` out 32: return address for BL (`pc_out`+4 of the branch).
- `link_we` out 1: one-cycle pulse; write `link_addr` to R14.

## Operation
- States: RESET, FETCH, DROP.
- RESET is entered on reset. The next cycle is FETCH with `fetch_pc`=`RESET_PC`.
- FETCH: `imem_req`=1 when no request is outstanding and either the output register is free or the skid buffer is empty. Once asserted, it stays asserted until ack.
- On ack, the data goes to the output register if it is empty or being consumed (`!stall`). Otherwise it goes to a one-entry skid buffer. `fetch_pc` += 4.
- When the output drains with `!stall`, the skid buffer moves into the output register first.
- Redirect: occurs when `branch_taken` && `inst_valid` && `!stall`.
  - target = `pc_out` + 8 + `b_offset`, modulo 2^32, with bits [1:0] forced to 0.
  - Output register and skid buffer are invalidated. Next cycle shows `BUBBLE` with `inst_valid`=0.
  - `fetch_pc` = target.
  - If a request is outstanding without ack in the redirect cycle, go to DROP. If the request is acked in that same cycle, its data is discarded, and the next request is issued to target.
- DROP: keep `imem_req`/`imem_addr` of the stale request until ack. Discard the data, then go to FETCH at target. `branch_taken` is ignored in DROP because `inst_valid`=0.
- Link: in the redirect cycle with `branch_link`=1, `link_addr` = `pc_out` + 4 and `link_we`=1 (registered, visible the next cycle for one cycle).
- `branch_taken` while `stall`=1 is not acted on. It is re-evaluated when the stall clears.
- Reset mid-transaction: state returns to RESET and any pending ack is ignored. Memory must tolerate an abandoned request.

## Timing
- Reset values of outputs: `imem_req`=0, `imem_addr`=`RESET_PC`, `instruction`=`BUBBLE`, `inst_valid`=0, `pc_out`=0, `link_addr`=0, `link_we`=0.
- First request is issued the cycle after `reset` falls. With a zero-wait ack, the first `inst_valid`=1 appears one cycle later.
- Steady state with zero-wait memory and no stall: one instruction per cycle.
- Redirect penalty with zero-wait memory: two bubble cycles before the target instruction is valid.
- Each extra wait state of a dropped request adds one cycle.
- `stall` affects outputs at the next edge only. Outputs are fully registered, with no combinational path from `stall` to `instruction`.
- The skid buffer guarantees no fetched word is lost or duplicated across any stall/ack interleaving.

## Test plan
- Reset release, zero-wait memory returning `imem_rdata`=addr: `imem_addr` is 0, 4, 8, ... on consecutive cycles; `pc_out` 0, 4, 8 with `inst_valid`=1 from the 2nd cycle after reset falls.
- Stall asserted for 3 cycles while an ack arrives: `instruction` holds at pc 0x8; on release, pc 0xC then 0x10 appear in consecutive cycles with no gap or duplicate.
- `branch_taken` at `pc_out`=0x10 with `b_offset`=0x20: two `BUBBLE` cycles (`instruction`=F000_0000), then `pc_out`=0x38.
- BL at `pc_out`=0x40 with `b_offset`=0xFFFF_FFF0 (-16): `link_we` pulse with `link_addr`=0x44; next valid `pc_out`=0x38.
- Redirect while memory has 3 wait states outstanding on 0x14: `imem_addr` stays 0x14 until ack, that data is never presented, then `imem_addr`=target.
- Reset asserted during DROP: next cycles show reset values; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage: PC, imem req/ack handshake, skid
//                buffer and taken-branch redirect with wrong-path squash.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] BUBBLE   = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        branch_link,
    input  logic [31:0] b_offset,
    output logic [31:0] instruction,
    output logic        inst_valid,
    output logic [31:0] pc_out,
    output logic [31:0] link_addr,
    output logic        link_we
);

    localparam logic [1:0]  c_ST_RESET  = 2'd0;
    localparam logic [1:0]  c_ST_FETCH  = 2'd1;
    localparam logic [1:0]  c_ST_DROP   = 2'd2;
    localparam logic [31:0] c_WORD_MASK = 32'hFFFF_FFFC;

    logic [1:0]  r_state;
    logic        r_req;
    logic [31:0] r_addr;
    logic [31:0] r_fetch_pc;
    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic [31:0] r_out_pc;
    logic        r_skid_valid;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;
    logic [31:0] r_link_addr;
    logic        r_link_we;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_ack;
    logic        w_out_free;
    logic [31:0] w_fetch_pc_nxt;
    logic        w_out_valid_nxt;
    logic [31:0] w_out_instr_nxt;
    logic [31:0] w_out_pc_nxt;
    logic        w_skid_valid_nxt;
    logic [31:0] w_skid_instr_nxt;
    logic [31:0] w_skid_pc_nxt;

    assign w_redirect     = (r_state == c_ST_FETCH) && r_out_valid && branch_taken && !stall;
    assign w_target       = (r_out_pc + 32'd8 + b_offset) & c_WORD_MASK;
    // Data acked in a redirect cycle belongs to the wrong path and is dropped.
    assign w_ack          = (r_state == c_ST_FETCH) && r_req && imem_ack && !w_redirect;
    assign w_out_free     = !r_out_valid || !stall;
    assign w_fetch_pc_nxt = w_ack ? (r_fetch_pc + 32'd4) : r_fetch_pc;

    always_comb begin
        w_out_valid_nxt  = r_out_valid;
        w_out_instr_nxt  = r_out_instr;
        w_out_pc_nxt     = r_out_pc;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_instr_nxt = r_skid_instr;
        w_skid_pc_nxt    = r_skid_pc;
        if (w_redirect) begin
            w_out_valid_nxt  = 1'b0;
            w_out_instr_nxt  = BUBBLE;
            w_skid_valid_nxt = 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                w_out_valid_nxt  = 1'b1;
                w_out_instr_nxt  = r_skid_instr;
                w_out_pc_nxt     = r_skid_pc;
                w_skid_valid_nxt = w_ack;
                w_skid_instr_nxt = imem_rdata;
                w_skid_pc_nxt    = r_addr;
            end else if (w_ack) begin
                w_out_valid_nxt  = 1'b1;
                w_out_instr_nxt  = imem_rdata;
                w_out_pc_nxt     = r_addr;
            end else begin
                w_out_valid_nxt  = 1'b0;
                w_out_instr_nxt  = BUBBLE;
            end
        end else if (w_ack) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_instr_nxt = imem_rdata;
            w_skid_pc_nxt    = r_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_RESET;
            r_req        <= 1'b0;
            r_addr       <= RESET_PC & c_WORD_MASK;
            r_fetch_pc   <= RESET_PC & c_WORD_MASK;
            r_out_valid  <= 1'b0;
            r_out_instr  <= BUBBLE;
            r_out_pc     <= 32'd0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= BUBBLE;
            r_skid_pc    <= 32'd0;
            r_link_addr  <= 32'd0;
            r_link_we    <= 1'b0;
        end else begin
            r_out_valid  <= w_out_valid_nxt;
            r_out_instr  <= w_out_instr_nxt;
            r_out_pc     <= w_out_pc_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_instr <= w_skid_instr_nxt;
            r_skid_pc    <= w_skid_pc_nxt;

            r_link_we <= w_redirect && branch_link;
            if (w_redirect && branch_link) begin
                r_link_addr <= r_out_pc + 32'd4;
            end

            case (r_state)
                c_ST_RESET: begin
                    r_state    <= c_ST_FETCH;
                    r_req      <= 1'b1;
                    r_addr     <= RESET_PC & c_WORD_MASK;
                    r_fetch_pc <= RESET_PC & c_WORD_MASK;
                end
                c_ST_FETCH: begin
                    if (w_redirect) begin
                        r_fetch_pc <= w_target;
                        // An unacked stale request must still be completed.
                        if (r_req && !imem_ack) begin
                            r_state <= c_ST_DROP;
                        end else begin
                            r_req <= 1'b0;
                        end
                    end else begin
                        r_fetch_pc <= w_fetch_pc_nxt;
                        if (!(r_req && !imem_ack)) begin
                            r_req  <= !(w_out_valid_nxt && w_skid_valid_nxt);
                            r_addr <= w_fetch_pc_nxt;
                        end
                    end
                end
                c_ST_DROP: begin
                    if (imem_ack) begin
                        r_state <= c_ST_FETCH;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_ST_RESET;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instruction = r_out_instr;
    assign inst_valid  = r_out_valid;
    assign pc_out      = r_out_pc;
    assign link_addr   = r_link_addr;
    assign link_we     = r_link_we;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed vector bench for fetch_unit with an addr-echo
//                instruction memory and programmable wait states.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] c_BUBBLE = 32'hF000_0000;
    localparam int          c_NVEC   = 30;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic        branch_link;
    logic [31:0] b_offset;
    logic [31:0] instruction;
    logic        inst_valid;
    logic [31:0] pc_out;
    logic [31:0] link_addr;
    logic        link_we;

    int errors = 0;
    int checks = 0;
    int wait_states = 0;
    int wcnt = 0;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .BUBBLE   (32'hF000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_link  (branch_link),
        .b_offset     (b_offset),
        .instruction  (instruction),
        .inst_valid   (inst_valid),
        .pc_out       (pc_out),
        .link_addr    (link_addr),
        .link_we      (link_we)
    );

    always #5 clk = ~clk;

    // Memory: acks after wait_states cycles of a held request, returns its address.
    always @(posedge clk) begin
        if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else                       wcnt <= 0;
    end
    assign imem_ack   = imem_req && (wcnt >= wait_states);
    assign imem_rdata = imem_addr;

    typedef struct {
        logic        st;
        logic        bt;
        logic        bl;
        logic [31:0] off;
        int          ws;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_lwe;
        logic [31:0] e_la;
    } vec_t;

    vec_t vecs [c_NVEC];

    function automatic vec_t mk(input logic st, input logic bt, input logic bl,
                                input logic [31:0] off, input int ws,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_pc,
                                input logic e_lwe, input logic [31:0] e_la);
        vec_t v;
        v.st = st; v.bt = bt; v.bl = bl; v.off = off; v.ws = ws;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        v.e_lwe = e_lwe; v.e_la = e_la;
        return v;
    endfunction

    task automatic chk(input string name, input int cyc,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    initial begin
        // st bt bl off ws | req addr | valid pc | link_we link_addr
        vecs[0]  = mk(0,0,0,32'h0,        0, 0,32'h0,   0,32'h0,   0,32'h0);
        vecs[1]  = mk(0,0,0,32'h0,        0, 1,32'h0,   0,32'h0,   0,32'h0);
        vecs[2]  = mk(0,0,0,32'h0,        0, 1,32'h4,   1,32'h0,   0,32'h0);
        vecs[3]  = mk(0,0,0,32'h0,        0, 1,32'h8,   1,32'h4,   0,32'h0);
        vecs[4]  = mk(1,0,0,32'h0,        0, 1,32'hC,   1,32'h8,   0,32'h0);
        vecs[5]  = mk(1,0,0,32'h0,        0, 0,32'h0,   1,32'h8,   0,32'h0);
        vecs[6]  = mk(1,0,0,32'h0,        0, 0,32'h0,   1,32'h8,   0,32'h0);
        vecs[7]  = mk(0,0,0,32'h0,        0, 0,32'h0,   1,32'h8,   0,32'h0);
        vecs[8]  = mk(0,0,0,32'h0,        0, 1,32'h10,  1,32'hC,   0,32'h0);
        vecs[9]  = mk(0,1,0,32'h20,       0, 1,32'h14,  1,32'h10,  0,32'h0);
        vecs[10] = mk(0,1,0,32'h500,      0, 0,32'h0,   0,32'h0,   0,32'h0);
        vecs[11] = mk(0,0,0,32'h0,        0, 1,32'h38,  0,32'h0,   0,32'h0);
        vecs[12] = mk(0,0,0,32'h0,        0, 1,32'h3C,  1,32'h38,  0,32'h0);
        vecs[13] = mk(0,0,0,32'h0,        0, 1,32'h40,  1,32'h3C,  0,32'h0);
        vecs[14] = mk(0,1,1,32'hFFFF_FFF0,0, 1,32'h44,  1,32'h40,  0,32'h0);
        vecs[15] = mk(0,0,0,32'h0,        0, 0,32'h0,   0,32'h0,   1,32'h44);
        vecs[16] = mk(0,0,0,32'h0,        0, 1,32'h38,  0,32'h0,   0,32'h44);
        vecs[17] = mk(0,0,0,32'h0,        0, 1,32'h3C,  1,32'h38,  0,32'h44);
        vecs[18] = mk(0,1,0,32'hFFFF_FFCC,0, 1,32'h40,  1,32'h3C,  0,32'h44);
        vecs[19] = mk(0,0,0,32'h0,        0, 0,32'h0,   0,32'h0,   0,32'h44);
        vecs[20] = mk(0,0,0,32'h0,        0, 1,32'h10,  0,32'h0,   0,32'h44);
        vecs[21] = mk(0,1,0,32'h100,      3, 1,32'h14,  1,32'h10,  0,32'h44);
        vecs[22] = mk(0,0,0,32'h0,        3, 1,32'h14,  0,32'h0,   0,32'h44);
        vecs[23] = mk(0,1,0,32'h500,      3, 1,32'h14,  0,32'h0,   0,32'h44);
        vecs[24] = mk(0,0,0,32'h0,        3, 1,32'h14,  0,32'h0,   0,32'h44);
        vecs[25] = mk(0,0,0,32'h0,        0, 0,32'h0,   0,32'h0,   0,32'h44);
        vecs[26] = mk(0,0,0,32'h0,        0, 1,32'h118, 0,32'h0,   0,32'h44);
        vecs[27] = mk(1,1,0,32'h40,       0, 1,32'h11C, 1,32'h118, 0,32'h44);
        vecs[28] = mk(0,0,0,32'h0,        0, 0,32'h0,   1,32'h118, 0,32'h44);
        vecs[29] = mk(0,1,0,32'h0,        2, 1,32'h120, 1,32'h11C, 0,32'h44);

        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_link = 1'b0;
        b_offset = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_imem_addr", -1, imem_addr, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < c_NVEC; i++) begin
            stall        = vecs[i].st;
            branch_taken = vecs[i].bt;
            branch_link  = vecs[i].bl;
            b_offset     = vecs[i].off;
            wait_states  = vecs[i].ws;
            chk("imem_req", i, {31'b0, imem_req}, {31'b0, vecs[i].e_req});
            if (vecs[i].e_req) chk("imem_addr", i, imem_addr, vecs[i].e_addr);
            chk("inst_valid", i, {31'b0, inst_valid}, {31'b0, vecs[i].e_valid});
            if (vecs[i].e_valid) chk("pc_out", i, pc_out, vecs[i].e_pc);
            chk("instruction", i, instruction, vecs[i].e_valid ? vecs[i].e_pc : c_BUBBLE);
            chk("link_we", i, {31'b0, link_we}, {31'b0, vecs[i].e_lwe});
            chk("link_addr", i, link_addr, vecs[i].e_la);
            @(negedge clk);
        end

        // Cycle 30: DROP holding the stale 0x120 request; reset arrives now.
        branch_taken = 1'b0;
        chk("drop_req", 30, {31'b0, imem_req}, 32'd1);
        chk("drop_addr", 30, imem_addr, 32'h120);
        chk("drop_instruction", 30, instruction, c_BUBBLE);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_req", 31, {31'b0, imem_req}, 32'd0);
        chk("rst_addr", 31, imem_addr, 32'h0);
        chk("rst_valid", 31, {31'b0, inst_valid}, 32'd0);
        chk("rst_instruction", 31, instruction, c_BUBBLE);
        chk("rst_pc_out", 31, pc_out, 32'h0);
        chk("rst_link_addr", 31, link_addr, 32'h0);
        chk("rst_link_we", 31, {31'b0, link_we}, 32'd0);
        reset = 1'b0;
        wait_states = 0;
        @(negedge clk);
        chk("restart_req", 32, {31'b0, imem_req}, 32'd1);
        chk("restart_addr", 32, imem_addr, 32'h0);
        chk("restart_valid", 32, {31'b0, inst_valid}, 32'd0);
        @(negedge clk);
        chk("restart_valid", 33, {31'b0, inst_valid}, 32'd1);
        chk("restart_pc", 33, pc_out, 32'h0);
        chk("restart_instruction", 33, instruction, 32'h0);
        chk("restart_addr", 33, imem_addr, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
